// File: rtl/apb_master.sv
// apb_master: single-outstanding APB master.
// Takes one command at a time on a valid/ready interface, runs it as an APB
// SETUP/ACCESS transfer and reports completion with a one-cycle response
// pulse that carries read data or a timeout flag.
//
// Handshake: a command is accepted on a rising PCLK edge where cmd_valid and
// cmd_ready are both 1; cmd_ready is only high while no transfer is in
// flight. rsp_valid is a one-cycle pulse with no back-pressure.
module apb_master #(
   parameter int DATAWIDTH = 32,
   parameter int ADDRWIDTH = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 PCLK,
   input  logic                 PRESETn,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDRWIDTH-1:0] cmd_addr,
   input  logic [DATAWIDTH-1:0] cmd_wdata,
   output logic                 rsp_valid,
   output logic [DATAWIDTH-1:0] rsp_rdata,
   output logic                 rsp_timeout,
   output logic [ADDRWIDTH-1:0] PADDR,
   output logic                 PWRITE,
   output logic                 PSEL,
   output logic                 PENABLE,
   output logic [DATAWIDTH-1:0] PWDATA,
   input  logic [DATAWIDTH-1:0] PRDATA,
   input  logic                 PREADY
);

   // Wait-state counter wide enough to hold TIMEOUT; one bit when disabled.
   localparam int CNTW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] TO_VAL  = CNTW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   state_t                 r_state;
   logic [CNTW-1:0]        r_cnt;
   logic                   r_cmd_ready;
   logic                   r_rsp_valid;
   logic [DATAWIDTH-1:0]   r_rsp_rdata;
   logic                   r_rsp_timeout;
   logic [ADDRWIDTH-1:0]   r_paddr;
   logic                   r_pwrite;
   logic                   r_psel;
   logic                   r_penable;
   logic [DATAWIDTH-1:0]   r_pwdata;

   logic [CNTW-1:0]        w_cnt_next;
   logic                   w_timeout_hit;

   // Saturating increment of the wait counter and the abort condition for
   // an ACCESS edge with PREADY low.
   always_comb begin
      w_cnt_next    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
      w_timeout_hit = (TIMEOUT != 0) && (w_cnt_next == TO_VAL);
   end

   // Transfer FSM with all outputs registered; reset returns the bus to idle
   // immediately and drops any in-flight command without a response.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_cmd_ready   <= 1'b1;
         r_rsp_valid   <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_timeout <= 1'b0;
         r_paddr       <= '0;
         r_pwrite      <= 1'b0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwdata      <= '0;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_paddr     <= cmd_addr;
                  r_pwrite    <= cmd_write;
                  r_pwdata    <= cmd_wdata;
                  r_psel      <= 1'b1;
                  r_penable   <= 1'b0;
                  r_cmd_ready <= 1'b0;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_cnt     <= '0;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // PREADY takes priority over a coincident timeout.
               if (PREADY) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_timeout <= 1'b0;
                  if (!r_pwrite) begin
                     r_rsp_rdata <= PRDATA;
                  end
                  r_cmd_ready   <= 1'b1;
                  r_state       <= ST_IDLE;
               end else begin
                  r_cnt <= w_cnt_next;
                  if (w_timeout_hit) begin
                     r_psel        <= 1'b0;
                     r_penable     <= 1'b0;
                     r_rsp_valid   <= 1'b1;
                     r_rsp_timeout <= 1'b1;
                     r_rsp_rdata   <= '0;
                     r_cmd_ready   <= 1'b1;
                     r_state       <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_psel      <= 1'b0;
               r_penable   <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready   = r_cmd_ready;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_timeout = r_rsp_timeout;
   assign PADDR       = r_paddr;
   assign PWRITE      = r_pwrite;
   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed bench for apb_master with a transaction-level
// model (accept cycle, number of ACCESS edges, expected response) checked
// against the DUT outputs on every clock, plus literal spot checks.
module tb_apb_master;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int TO = 4;

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [DW-1:0] cmd_wdata = '0;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_timeout;
   logic [AW-1:0] PADDR;
   logic          PWRITE;
   logic          PSEL;
   logic          PENABLE;
   logic [DW-1:0] PWDATA;
   logic [DW-1:0] PRDATA = '0;
   logic          PREADY = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int wait_cfg = 0;   // PREADY-low ACCESS edges the slave inserts

   logic [DW-1:0] slv_mem [16];
   logic [DW-1:0] exp_mem [16];

   apb_master #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- APB slave (drives on negedge) ----------------
   int k = 0;
   always @(negedge PCLK) begin
      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
         if (k >= wait_cfg) begin
            PREADY = 1'b1;
            if (PWRITE) begin
               slv_mem[PADDR] = PWDATA;
               PRDATA = 32'hBADC0DE0;
            end else begin
               PRDATA = slv_mem[PADDR];
            end
         end else begin
            PREADY = 1'b0;
            PRDATA = 32'hBADC0DE0 ^ k;
         end
         k++;
      end else begin
         PREADY = 1'b0;
         PRDATA = 32'h0BAD0BAD;
         k = 0;
      end
   end

   // ---------------- transaction model + per-cycle compare ----------------
   bit            m_busy = 0;
   int            m_acc, m_len;
   bit            m_to, m_write;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   logic [DW-1:0] m_rdata = '0;
   logic          m_rto = 1'b0;

   always @(posedge PCLK) begin
      logic          v_edge, r_edge, wr_edge;
      logic [AW-1:0] a_edge;
      logic [DW-1:0] d_edge;
      logic          e_psel, e_pen, e_rsp, e_rdy;
      int            w, r;
      v_edge = cmd_valid; r_edge = PRESETn; wr_edge = cmd_write;
      a_edge = cmd_addr;  d_edge = cmd_wdata; w = wait_cfg;
      #1;
      if (!r_edge || !PRESETn) begin
         m_busy = 0; m_rdata = '0; m_rto = 1'b0;
         check("rst_psel", PSEL, 0);
         check("rst_penable", PENABLE, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_rsp_rdata", rsp_rdata, 0);
         check("rst_rsp_timeout", rsp_timeout, 0);
      end else begin
         if (m_busy && cyc >= m_acc + m_len + 2) m_busy = 0;
         if (!m_busy && v_edge) begin
            m_busy = 1; m_acc = cyc; m_write = wr_edge; m_addr = a_edge; m_wdata = d_edge;
            m_to  = (w >= TO);
            m_len = m_to ? TO : w + 1;
         end
         e_psel = 0; e_pen = 0; e_rsp = 0; e_rdy = 1;
         if (m_busy) begin
            r = cyc - m_acc;
            e_psel = (r <= m_len);
            e_pen  = (r >= 1) && (r <= m_len);
            e_rsp  = (r == m_len + 1);
            e_rdy  = (r > m_len);
            if (e_rsp) begin
               m_rto = m_to;
               if (m_to) m_rdata = '0;
               else if (m_write) exp_mem[m_addr] = m_wdata;
               else m_rdata = exp_mem[m_addr];
            end
         end
         check("psel", PSEL, e_psel);
         check("penable", PENABLE, e_pen);
         check("rsp_valid", rsp_valid, e_rsp);
         check("cmd_ready", cmd_ready, e_rdy);
         check("rsp_rdata", rsp_rdata, m_rdata);
         check("rsp_timeout", rsp_timeout, m_rto);
         if (e_psel) begin
            check("paddr", PADDR, m_addr);
            check("pwrite", PWRITE, m_write);
            check("pwdata", PWDATA, m_wdata);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit keep, output int acc);
      bit ok = 0;
      acc = -1;
      @(negedge PCLK);
      cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         if (cmd_ready) begin
            @(posedge PCLK); #1;
            acc = cyc; ok = 1;
            break;
         end
         @(negedge PCLK);
      end
      if (!keep || !ok) cmd_valid = 1'b0;
      check("cmd_accepted", ok, 1);
   endtask

   task automatic wait_rsp(input int acc, output int lat);
      bit found = 0;
      lat = -1;
      for (int i = 0; i < 64; i++) begin
         @(posedge PCLK); #1;
         if (rsp_valid) begin
            found = 1; lat = cyc - acc;
            break;
         end
      end
      check("rsp_seen", found, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int a0, a1, a2, lat;
      for (int i = 0; i < 16; i++) begin
         slv_mem[i] = 32'h1000_0000 + i;
         exp_mem[i] = 32'h1000_0000 + i;
      end
      repeat (2) @(posedge PCLK);
      #1;
      check("reset_paddr", PADDR, 0);
      check("reset_pwrite", PWRITE, 0);
      check("reset_pwdata", PWDATA, 0);
      @(negedge PCLK); PRESETn = 1'b1;
      @(posedge PCLK); #1;
      check("ready_after_reset", cmd_ready, 1);

      // zero-wait write then read back
      wait_cfg = 0;
      drive(1, 4'd3, 32'hDEADBEEF, 0, a0); wait_rsp(a0, lat);
      check("wr0_latency", lat, 2);
      check("wr0_timeout", rsp_timeout, 0);
      drive(0, 4'd3, 32'h0, 0, a0); wait_rsp(a0, lat);
      check("rd0_latency", lat, 2);
      check("rd0_data", rsp_rdata, 32'hDEADBEEF);

      // three wait states: PREADY wins on what would be the TIMEOUT-th edge
      wait_cfg = 3;
      drive(1, 4'd9, 32'h12345678, 0, a0); wait_rsp(a0, lat);
      check("wait3_latency", lat, 5);
      check("wait3_timeout", rsp_timeout, 0);
      check("wait3_rdata_held", rsp_rdata, 32'hDEADBEEF);

      // slave never ready: abort after TIMEOUT ACCESS edges
      wait_cfg = 1000;
      drive(0, 4'd7, 32'h0, 0, a0); wait_rsp(a0, lat);
      check("to_latency", lat, 5);
      check("to_flag", rsp_timeout, 1);
      check("to_rdata", rsp_rdata, 0);
      check("to_psel", PSEL, 0);
      check("to_ready", cmd_ready, 1);

      // back-to-back with cmd_valid held high
      wait_cfg = 0;
      drive(1, 4'd1, 32'h1111_0001, 1, a0);
      drive(1, 4'd2, 32'h2222_0002, 1, a1);
      drive(0, 4'd1, 32'h0, 0, a2);
      check("b2b_gap1", a1 - a0, 3);
      check("b2b_gap2", a2 - a1, 3);
      wait_rsp(a2, lat);
      check("b2b_rd_latency", lat, 2);
      check("b2b_rd_data", rsp_rdata, 32'h1111_0001);

      // asynchronous reset in the middle of ACCESS
      wait_cfg = 1000;
      drive(1, 4'd5, 32'hFFFF_0000, 0, a0);
      @(posedge PCLK); #1;
      check("pre_rst_penable", PENABLE, 1);
      #2 PRESETn = 1'b0;
      #1;
      check("async_psel", PSEL, 0);
      check("async_penable", PENABLE, 0);
      check("async_rsp_valid", rsp_valid, 0);
      repeat (2) @(posedge PCLK);
      @(negedge PCLK); PRESETn = 1'b1;
      repeat (4) @(posedge PCLK);
      #1;
      check("post_rst_no_rsp", rsp_valid, 0);
      wait_cfg = 1;
      drive(1, 4'd5, 32'h55AA_55AA, 0, a0); wait_rsp(a0, lat);
      check("post_rst_wr_latency", lat, 3);
      wait_cfg = 0;
      drive(0, 4'd5, 32'h0, 0, a0); wait_rsp(a0, lat);
      check("post_rst_rd_data", rsp_rdata, 32'h55AA_55AA);

      repeat (3) @(posedge PCLK);
      #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
